// File: rtl/seg_reader.sv
// seg_reader: samples a multiplexed 7-segment display bus (8 digits, active-low)
// and rebuilds the 32-bit hex word it shows.
//
// A digit is sampled once it has been held unchanged for STABLE_CYCLES
// cycles. Digits must arrive in order 0..7. A complete frame is then offered
// on a valid/ready output port.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   hex_in      segment bus, active-low, bit 6 = g .. bit 0 = a
//   hex_on_in   digit select, active-low, bit k low selects digit k
//   word_ready  consumer accepts word_out while word_valid is high
//   word_out    captured word, digit k in bits [4k+3:4k]
//   word_err    per-digit flag, set when the digit held an undecodable pattern
//   word_valid  word_out/word_err hold a complete frame
//   frame_err   one-cycle pulse on an out-of-sequence digit
//   overrun     one-cycle pulse when a completed frame is dropped
module seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  hex_in,
    input  logic [7:0]  hex_on_in,
    input  logic        word_ready,
    output logic [31:0] word_out,
    output logic [7:0]  word_err,
    output logic        word_valid,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [7:0] STB = 8'(STABLE_CYCLES);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    // Input capture and the previous captured value for change detection.
    logic [7:0]  r_on;
    logic [6:0]  r_hex;
    logic [14:0] r_prev;
    logic [7:0]  r_cnt;

    // One-cycle sample pipeline feeding the FSM.
    logic        r_smp;
    logic [2:0]  r_smp_idx;
    logic [3:0]  r_smp_nib;
    logic        r_smp_bad;

    state_t          r_st, w_st_n;
    logic [2:0]      r_exp, w_exp_n;
    logic [7:0][3:0] r_sh_nib, w_sh_nib_n;
    logic [7:0]      r_sh_err, w_sh_err_n;
    logic [7:0][3:0] r_word, w_word_n;
    logic [7:0]      r_err, w_err_n;
    logic            r_vld, w_vld_n;
    logic            r_ferr, w_ferr_n;
    logic            r_ovr, w_ovr_n;

    logic [7:0] w_sel;
    logic       w_sel_valid;
    logic       w_changed;
    logic [7:0] w_cnt_n;
    logic       w_sample;
    logic [2:0] w_idx;
    logic [3:0] w_nib;
    logic       w_bad;
    logic       w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_on   <= '1;
            r_hex  <= '1;
            r_prev <= '1;
        end else begin
            r_on   <= hex_on_in;
            r_hex  <= hex_in;
            r_prev <= {r_on, r_hex};
        end
    end

    // Exactly one select line low.
    assign w_sel       = ~r_on;
    assign w_sel_valid = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);
    assign w_changed   = ({r_on, r_hex} != r_prev);

    // The counter holds the number of cycles the current value has been seen,
    // so the first cycle of a new value loads 1 and a dwell of N cycles reaches N.
    // It stops at STB, which also blocks re-sampling within one dwell.
    always_comb begin
        w_cnt_n = r_cnt;
        if (!w_sel_valid)
            w_cnt_n = 8'd0;
        else if (w_changed)
            w_cnt_n = 8'd1;
        else if (r_cnt != STB)
            w_cnt_n = r_cnt + 8'd1;
    end

    assign w_sample = w_sel_valid && (w_cnt_n == STB) && (w_changed || (r_cnt != STB));

    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < 8; k++)
            if (w_sel[k]) w_idx = 3'(k);
    end

    always_comb begin
        w_bad = 1'b0;
        case (r_hex)
            7'b1000000: w_nib = 4'h0;
            7'b1111001: w_nib = 4'h1;
            7'b0100100: w_nib = 4'h2;
            7'b0110000: w_nib = 4'h3;
            7'b0011001: w_nib = 4'h4;
            7'b0010010: w_nib = 4'h5;
            7'b0000010: w_nib = 4'h6;
            7'b1111000: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0010000: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0000011: w_nib = 4'hB;
            7'b1000110: w_nib = 4'hC;
            7'b0100001: w_nib = 4'hD;
            7'b0000110: w_nib = 4'hE;
            7'b0001110: w_nib = 4'hF;
            default: begin
                w_nib = 4'h0;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_smp     <= 1'b0;
            r_smp_idx <= '0;
            r_smp_nib <= '0;
            r_smp_bad <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_n;
            r_smp     <= w_sample;
            r_smp_idx <= w_idx;
            r_smp_nib <= w_nib;
            r_smp_bad <= w_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st     <= S_IDLE;
            r_exp    <= '0;
            r_sh_nib <= '0;
            r_sh_err <= '0;
            r_word   <= '0;
            r_err    <= '0;
            r_vld    <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_st     <= w_st_n;
            r_exp    <= w_exp_n;
            r_sh_nib <= w_sh_nib_n;
            r_sh_err <= w_sh_err_n;
            r_word   <= w_word_n;
            r_err    <= w_err_n;
            r_vld    <= w_vld_n;
            r_ferr   <= w_ferr_n;
            r_ovr    <= w_ovr_n;
        end
    end

    always_comb begin
        w_st_n     = r_st;
        w_exp_n    = r_exp;
        w_sh_nib_n = r_sh_nib;
        w_sh_err_n = r_sh_err;
        w_word_n   = r_word;
        w_err_n    = r_err;
        w_vld_n    = r_vld;
        w_ferr_n   = 1'b0;
        w_ovr_n    = 1'b0;
        w_done     = 1'b0;

        if (r_vld && word_ready)
            w_vld_n = 1'b0;

        if (r_smp) begin
            case (r_st)
                S_IDLE: begin
                    // Only digit 0 can open a frame; anything else is ignored.
                    if (r_smp_idx == 3'd0) begin
                        w_sh_nib_n    = '0;
                        w_sh_err_n    = '0;
                        w_sh_nib_n[0] = r_smp_nib;
                        w_sh_err_n[0] = r_smp_bad;
                        w_exp_n       = 3'd1;
                        w_st_n        = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (r_smp_idx == r_exp) begin
                        w_sh_nib_n[r_smp_idx] = r_smp_nib;
                        w_sh_err_n[r_smp_idx] = r_smp_bad;
                        if (r_exp == 3'd7) begin
                            w_done  = 1'b1;
                            w_st_n  = S_IDLE;
                            w_exp_n = 3'd0;
                        end else begin
                            w_exp_n = r_exp + 3'd1;
                        end
                    end else begin
                        w_ferr_n   = 1'b1;
                        w_sh_nib_n = '0;
                        w_sh_err_n = '0;
                        w_st_n     = S_IDLE;
                        w_exp_n    = 3'd0;
                        // An out-of-order digit 0 is a fresh frame start.
                        if (r_smp_idx == 3'd0) begin
                            w_sh_nib_n[0] = r_smp_nib;
                            w_sh_err_n[0] = r_smp_bad;
                            w_exp_n       = 3'd1;
                            w_st_n        = S_COLLECT;
                        end
                    end
                end
                default: begin
                    w_st_n  = S_IDLE;
                    w_exp_n = 3'd0;
                end
            endcase
        end

        // A completed frame is published if the output slot is free or being
        // freed on this very edge; otherwise it is dropped and flagged.
        if (w_done) begin
            if (!r_vld || word_ready) begin
                w_word_n = w_sh_nib_n;
                w_err_n  = w_sh_err_n;
                w_vld_n  = 1'b1;
            end else begin
                w_ovr_n = 1'b1;
            end
            w_sh_nib_n = '0;
            w_sh_err_n = '0;
        end
    end

    assign word_out   = r_word;
    assign word_err   = r_err;
    assign word_valid = r_vld;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule
